// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: mode-control inputs and registered video outputs of the pattern generator
//   key_n, mode_in, mode_load : button and direct-load mode requests (into the generator)
//   hs, vs, de, r, g, b       : sync, active-video enable and colour channels (out of the generator)
//   frame_start, mode         : first-cycle-of-frame pulse and currently displayed mode
//   master = generator side, slave = board/bench side
interface vga_pattern_gen_if #(parameter int BPC = 6);
  logic key_n;
  logic [3:0] mode_in;
  logic mode_load;
  logic hs, vs, de;
  logic [BPC-1:0] r, g, b;
  logic frame_start;
  logic [3:0] mode;
  modport master (input key_n, mode_in, mode_load, output hs, vs, de, r, g, b, frame_start, mode);
  modport slave (output key_n, mode_in, mode_load, input hs, vs, de, r, g, b, frame_start, mode);
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing and 14-mode test-pattern generator
//   clk  : pixel clock
//   rstn : asynchronous active-low reset
//   bus  : vga_pattern_gen_if.master (key_n, mode_in, mode_load in; hs, vs, de, r, g, b, frame_start, mode out)
//   Optional moving white box overlay when VGA_PATTERN_BOX_EN is defined (parameter BOX_SIZE).
module vga_pattern_gen #(
  parameter int H_ACT = 1024,
  parameter int H_FP = 24,
  parameter int H_SYNC = 136,
  parameter int H_BP = 160,
  parameter int V_ACT = 768,
  parameter int V_FP = 3,
  parameter int V_SYNC = 6,
  parameter int V_BP = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int BPC = 6,
  parameter int GRAD_SHIFT = 2,
  parameter int GRID_S = 4,
  parameter int GRID_L = 6,
  parameter int DEBOUNCE_CYC = 90000
`ifdef VGA_PATTERN_BOX_EN
  , parameter int BOX_SIZE = 32
`endif
) (
  input logic clk,
  input logic rstn,
  vga_pattern_gen_if.master bus
);
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int H0 = H_SYNC + H_BP;
  localparam int V0 = V_SYNC + V_BP;
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  // coordinates are zero-extended wide enough that gradient/grid bits above them read as 0
  localparam int E = HW + VW + GRAD_SHIFT + BPC + GRID_L;
  localparam int W = H_ACT / 8;
  localparam logic [BPC-1:0] F = '1;
  localparam logic [BPC-1:0] HV = {1'b1, {(BPC-1){1'b0}}};
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic h_end, v_end, de_n, fs_n;
  logic [E-1:0] x, y;
  logic [BPC-1:0] gx, gy, pr, pg, pb;
  logic [3:0] bar, pend;
  logic k1, k2, step, in_box;
  logic [CW-1:0] dcnt;
  always_comb begin
    h_end = h == HW'(H_TOT - 1);
    v_end = v == VW'(V_TOT - 1);
    fs_n = h == '0 && v == '0;
    de_n = h >= HW'(H0) && h < HW'(H0 + H_ACT) && v >= VW'(V0) && v < VW'(V0 + V_ACT);
    x = E'(h) - E'(H0);
    y = E'(v) - E'(V0);
    gx = x[GRAD_SHIFT +: BPC];
    gy = y[GRAD_SHIFT +: BPC];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h_end ? '0 : h + HW'(1);
      if (h_end) v <= v_end ? '0 : v + VW'(1);
    end
  // bar index = number of bar boundaries at or left of x; 8 means past the last full bar
  always_comb begin
    bar = '0;
    for (int k = 1; k <= 8; k++) if (x >= E'(k * W)) bar = bar + 4'd1;
  end
  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (bus.mode)
      4'd1, 4'd14, 4'd15: {pr, pg, pb} = {3{F}};
      4'd2: pr = F;
      4'd3: pg = F;
      4'd4: pb = F;
      4'd5: {pr, pg, pb} = x[GRID_S] == y[GRID_S] ? {3{F}} : '0;
      4'd6: {pr, pg, pb} = x[GRID_L] == y[GRID_L] ? {3{F}} : '0;
      4'd7: {pr, pg, pb} = {3{gx}};
      4'd8: {pr, pg, pb} = {3{gy}};
      4'd9: pr = gx;
      4'd10: pg = gx;
      4'd11: pb = gx;
      4'd12:
        case (bar)
          4'd0: pr = F;
          4'd1: pg = F;
          4'd2: pb = F;
          4'd3: {pr, pb} = {F, F};
          4'd4: {pr, pg} = {F, F};
          4'd5: {pg, pb} = {F, F};
          4'd6: {pr, pg, pb} = {3{F}};
          4'd7: {pr, pg} = {F, HV};
          default: ;
        endcase
      4'd13: {pr, pg, pb} = x == '0 || x == E'(H_ACT - 1) || y == '0 || y == E'(V_ACT - 1) ? {3{F}} : '0;
      default: ;
    endcase
  end
`ifdef VGA_PATTERN_BOX_EN
  logic [E-1:0] bx, by;
  logic dx, dy, ndx, ndy;
  always_comb begin
    ndx = dx ? bx != E'(H_ACT - BOX_SIZE) : bx == '0;
    ndy = dy ? by != E'(V_ACT - BOX_SIZE) : by == '0;
    in_box = x >= bx && x < bx + E'(BOX_SIZE) && y >= by && y < by + E'(BOX_SIZE);
  end
  // steps on the last cycle of a frame so each frame, the first included, draws at its own position
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bx <= '0;
      by <= '0;
      dx <= 1'b1;
      dy <= 1'b1;
    end else if (h_end && v_end) begin
      dx <= ndx;
      dy <= ndy;
      bx <= ndx ? bx + E'(1) : bx - E'(1);
      by <= ndy ? by + E'(1) : by - E'(1);
    end
`else
  assign in_box = 1'b0;
`endif
  assign step = !k2 && dcnt == CW'(DEBOUNCE_CYC - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      k1 <= 1'b1;
      k2 <= 1'b1;
      dcnt <= '0;
      pend <= '0;
      bus.mode <= '0;
    end else begin
      k1 <= bus.key_n;
      k2 <= k1;
      dcnt <= k2 ? '0 : dcnt == CW'(DEBOUNCE_CYC) ? dcnt : dcnt + CW'(1);
      pend <= bus.mode_load ? bus.mode_in : step ? (pend == 4'd13 ? 4'd0 : pend + 4'd1) : pend;
      if (fs_n) bus.mode <= pend;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      bus.hs <= !HS_POL;
      bus.vs <= !VS_POL;
      bus.de <= 1'b0;
      bus.frame_start <= 1'b0;
      {bus.r, bus.g, bus.b} <= '0;
    end else begin
      bus.hs <= (h < HW'(H_SYNC)) ~^ HS_POL;
      bus.vs <= (v < VW'(V_SYNC)) ~^ VS_POL;
      bus.de <= de_n;
      bus.frame_start <= fs_n;
      {bus.r, bus.g, bus.b} <= !de_n ? '0 : in_box ? {3{F}} : {pr, pg, pb};
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed self-checking bench for vga_pattern_gen on a 24x12 timing
module tb_vga_pattern_gen;
  localparam int BPC = 6;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  vga_pattern_gen_if #(.BPC(BPC)) bus ();
  vga_pattern_gen #(
    .H_ACT(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .BPC(BPC),
    .GRAD_SHIFT(2), .GRID_S(1), .GRID_L(6), .DEBOUNCE_CYC(10)
`ifdef VGA_PATTERN_BOX_EN
    , .BOX_SIZE(4)
`endif
  ) dut (.clk(clk), .rstn(rstn), .bus(bus));
  localparam logic [17:0] WHITE = 18'h3ffff;
  localparam logic [17:0] BLACK = 18'h0;
  int passed = 0;
  int total = 0;
  int t = 0;
  int f0 = 0;
  logic [17:0] rgb;
  assign rgb = {bus.r, bus.g, bus.b};
  function automatic logic [17:0] rgb3(input int r, input int g, input int b);
    return {6'(r), 6'(g), 6'(b)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    t++;
  endtask
  task automatic wait_fs();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (bus.frame_start !== 1'b1 && n < 400);
    chk("frame_start_seen", bus.frame_start, 1);
    f0 = t;
  endtask
  task automatic pix(input string tag, input int x, input int y, input logic [17:0] exp);
    int target = f0 + (y + 3) * 24 + x + 6;
    while (t < target) cyc();
    chk({tag, "_de"}, bus.de, 1);
    chk(tag, rgb, exp);
  endtask
  task automatic press(input int n);
    bus.key_n = 1'b0;
    repeat (n) cyc();
    bus.key_n = 1'b1;
    repeat (4) cyc();
  endtask
  task automatic load(input logic [3:0] m);
    bus.mode_in = m;
    bus.mode_load = 1'b1;
    cyc();
    bus.mode_load = 1'b0;
  endtask
  task automatic restart();
    rstn = 1'b1;
    t = -1;
    cyc();
    f0 = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached");
    $fatal(1);
  end
  initial begin
    bus.key_n = 1'b1;
    bus.mode_in = '0;
    bus.mode_load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", bus.hs, 1);
    chk("rst_vs", bus.vs, 1);
    chk("rst_de", bus.de, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_fs", bus.frame_start, 0);
    chk("rst_mode", bus.mode, 0);
    restart();
    chk("fs_first", bus.frame_start, 1);
    begin : frame_scan
      int hs_lo = 0, vs_lo = 0, de_n = 0, de_l3 = 0, fs_n = 0, first = -1;
      for (int i = 0; i < 288; i++) begin
        if (i > 0) cyc();
        if (bus.hs === 1'b0) hs_lo++;
        if (bus.vs === 1'b0) vs_lo++;
        if (bus.de === 1'b1) de_n++;
        if (bus.de === 1'b1 && t / 24 == 3) de_l3++;
        if (bus.frame_start === 1'b1) fs_n++;
        if (bus.de === 1'b1 && first < 0) first = t;
      end
      chk("hs_low_per_frame", hs_lo, 36);
      chk("vs_low_per_frame", vs_lo, 48);
      chk("de_per_frame", de_n, 128);
      chk("de_per_line", de_l3, 16);
      chk("fs_per_frame", fs_n, 1);
      chk("first_de_cycle", first, 78);
    end
    cyc();
    chk("fs_period", bus.frame_start, 1);
    press(5);
    wait_fs();
    chk("short_press_mode", bus.mode, 0);
    press(30);
    chk("mode_before_fs", bus.mode, 0);
    wait_fs();
    chk("long_press_mode", bus.mode, 1);
    cyc();
    chk("pre_rst_hs", bus.hs, 0);
    rstn = 1'b0;
    #1;
    chk("async_rst_hs", bus.hs, 1);
    chk("async_rst_vs", bus.vs, 1);
    chk("async_rst_de", bus.de, 0);
    chk("async_rst_rgb", rgb, 0);
    chk("async_rst_mode", bus.mode, 0);
    @(posedge clk);
    #1;
    restart();
    chk("fs_after_rst", bus.frame_start, 1);
    repeat (13) press(14);
    wait_fs();
    chk("mode_after_13", bus.mode, 13);
    pix("border_tl", 0, 0, WHITE);
    pix("border_in", 5, 3, BLACK);
    pix("border_r", 15, 3, WHITE);
    pix("border_b", 7, 7, WHITE);
    press(14);
    wait_fs();
    chk("mode_wrap", bus.mode, 0);
    bus.key_n = 1'b0;
    repeat (11) cyc();
    load(4'd12);
    repeat (5) cyc();
    bus.key_n = 1'b1;
    repeat (4) cyc();
    wait_fs();
    chk("load_priority", bus.mode, 12);
    pix("bar_x0", 0, 0, rgb3(63, 0, 0));
    pix("bar_x1", 1, 0, rgb3(63, 0, 0));
    pix("bar_x2", 2, 0, rgb3(0, 63, 0));
    pix("bar_x3", 3, 0, rgb3(0, 63, 0));
    pix("bar_x6", 6, 0, rgb3(63, 0, 63));
    pix("bar_x14", 14, 0, rgb3(63, 32, 0));
    pix("bar_x15", 15, 0, rgb3(63, 32, 0));
    load(4'd7);
    wait_fs();
    chk("mode_grad", bus.mode, 7);
    pix("grad_x13", 13, 0, rgb3(3, 3, 3));
    pix("grad_x4", 4, 1, rgb3(1, 1, 1));
    load(4'd5);
    chk("no_tear_mode", bus.mode, 7);
    pix("no_tear_pix", 13, 2, rgb3(3, 3, 3));
    wait_fs();
    chk("mode_grid", bus.mode, 5);
    pix("grid_00", 0, 0, WHITE);
    pix("grid_20", 2, 0, BLACK);
    pix("grid_22", 2, 2, WHITE);
    load(4'd10);
    wait_fs();
    pix("grad_green", 13, 0, rgb3(0, 3, 0));
`ifdef VGA_PATTERN_BOX_EN
    rstn = 1'b0;
    @(posedge clk);
    #1;
    restart();
    pix("box_f0_x0", 0, 0, WHITE);
    pix("box_f0_x3", 3, 0, WHITE);
    pix("box_f0_x4", 4, 0, BLACK);
    repeat (12) wait_fs();
    pix("box_f12_in", 12, 4, WHITE);
    pix("box_f12_out", 11, 4, BLACK);
    wait_fs();
    pix("box_f13_out", 10, 3, BLACK);
    pix("box_f13_in", 11, 3, WHITE);
    pix("box_f13_edge", 15, 3, BLACK);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Parametrised VGA timing and test-pattern generator: configurable resolution, porches, sync polarity and colour depth.
- Provides 14 selectable patterns, chosen by a debounced push-button or a direct load port.
- Pattern changes take effect only at a frame boundary.
- Sits between the pixel-clock PLL and the board DAC pins; it is the standard bring-up block for every video target.

Parameters:
- H_ACT, 1024, active pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACT, 768, active lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs
- BPC, 6, bits per colour channel (4..8)
- GRAD_SHIFT, 2, LSB of the active coordinate used for gradients
- GRID_S, 4, small-grid bit index
- GRID_L, 6, large-grid bit index
- DEBOUNCE_CYC, 90000, press duration that counts as one step

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- key_n  in  1  raw push-button, active-low, asynchronous to clk
- mode_in  in  4  mode value for direct load
- mode_load  in  1  one-cycle strobe: request mode_in
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  active-video enable
- r  out  BPC  red
- g  out  BPC  green
- b  out  BPC  blue
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- mode  out  4  currently displayed mode

Behaviour:
- Frame and line periods: H_TOT = H_SYNC+H_BP+H_ACT+H_FP; V_TOT likewise.
- h_cnt runs 0..H_TOT-1. v_cnt increments when h_cnt wraps; v_cnt runs 0..V_TOT-1.
- Sync regions: hs is asserted for h_cnt < H_SYNC; vs is asserted for v_cnt < V_SYNC.
- Active region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT) and v_cnt in the equivalent vertical window.
- Active coordinates x, y start at 0 at the first active pixel and line.
- Pipeline: hs, vs, de, r, g, b and frame_start are all registered with exactly 1 cycle latency from the counter state and are mutually aligned.
- RGB is forced to 0 when de=0.
- Reset values: counters 0; hs=!HS_POL; vs=!VS_POL; de=0; r=g=b=0; frame_start=0; mode=0; pending=0.
- frame_start fires for (h_cnt,v_cnt)=(0,0).
- Key path: key_n passes through a 2-flop synchroniser.
  - Released: debounce counter clears to 0.
  - Pressed: counter increments and saturates at DEBOUNCE_CYC.
  - Exactly one step request is issued when the counter equals DEBOUNCE_CYC-1.
- Mode request: pending register holds the next mode.
  - Step request sets pending = pending+1; it wraps 13 -> 0.
  - mode_load sets pending = mode_in.
  - If a step and mode_load occur in the same cycle, mode_load wins.
  - mode <= pending on the cycle frame_start is generated. Mid-frame requests never tear the image.
- Patterns by mode. F = all ones, H = MSB-only value.
  - 0: black.
  - 1: white.
  - 2: red.
  - 3: green.
  - 4: blue.
  - 5: white when x[GRID_S]==y[GRID_S], else black.
  - 6: same as 5 using bit GRID_L.
  - 7: gray, all channels = x[GRAD_SHIFT+BPC-1:GRAD_SHIFT].
  - 8: gray, same using y.
  - 9, 10, 11: the mode-7 value on R only, G only, B only respectively.
  - 12: eight bars, width W = H_ACT/8 (floor), in order R, G, B, magenta, yellow, cyan, white, orange (R=F, G=H, B=0). Pixels with x ≥ 8W are black.
  - 13: 1-pixel white border (x=0, x=H_ACT-1, y=0, y=V_ACT-1), black inside.
  - 14, 15: white.
- Gradient bits above the x/y width read as 0.
- Asynchronous reset mid-frame: all state returns to reset values immediately; the frame restarts from (0,0) after release.

Optional Feature:
- Macro: VGA_PATTERN_BOX_EN.
- When defined:
  - Adds parameter BOX_SIZE (default 32).
  - A BOX_SIZE×BOX_SIZE white square overlays every mode, in the active region only.
  - Position (bx,by) resets to (0,0) with direction (+1,+1).
  - At each frame_start the position moves 1 pixel per axis.
  - An axis reverses when the next step would exceed H_ACT-BOX_SIZE or V_ACT-BOX_SIZE, or go below 0.
- When undefined: no overlay, no extra registers, and output is identical to the base behaviour.

Test Plan:
- Timing: H_ACT=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACT=8, V_FP=1, V_SYNC=2, V_BP=1.
  - Required: hs low 3 of every 24 cycles; vs low 48 of every 288 cycles; de high 16 cycles per active line and 128 per frame.
  - Required: frame_start period 288.
  - Required: first de=1 one cycle after h_cnt=6, v_cnt=3.
- Reset: rstn low mid-line with hs asserted -> hs, vs, de, RGB, mode return to reset values combinationally; first frame_start 1 cycle after the first clk edge with rstn high.
- Debounce: DEBOUNCE_CYC=10.
  - 5-cycle press -> mode stays 0.
  - 30-cycle press -> mode becomes 1 at the next frame_start only.
  - 14 presses from mode 0 -> wraps to 0.
- Load priority: mode_load=1 with mode_in=12, in the same cycle a step request fires -> pending=12.
  - Required at next frame: x=0..1 red (R=63, G=0, B=0), x=2..3 green, x=14..15 orange (R=63, G=32, B=0).
- Gradient/grid: mode 7, BPC=6, GRAD_SHIFT=2 -> at x=13, R=G=B=3.
  - Required: mode 5 with GRID_S=1 -> at (x=2, y=0) RGB=0; at (x=2, y=2) RGB=63.
- Box (VGA_PATTERN_BOX_EN, BOX_SIZE=4) -> frame 0 overlay at x 0..3; frame 12 at bx=12; frame 13 at bx=11 (bounce). mode 0 pixels inside the box read 63.
